sq_gen: RTL

Programmable square-wave generator: produces a clock-synchronous square wave of a given period and high time, counted in system clock cycles. It is the stimulus-side counterpart to the frequency meter and drives the meter's `square` input in loopback self-test or feeds external DUTs. New settings take effect only at period boundaries, so no runt pulses are ever produced.

---
 rtl/sq_gen_pkg.sv | 22 ++
 rtl/sq_gen_if.sv | 50 +++++
 rtl/sq_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sq_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sq_gen_pkg                                                  |
// | Brief  : Shared types and constants for the square-wave generator.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package sq_gen_pkg;

   // Default width of the period, high-time and period-count fields.
   localparam int CNT_W_DEF  = 32;

   // Shortest period the generator will produce; anything below is clamped.
   localparam int MIN_PERIOD = 2;

   // Generator control states.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } sq_state_e;

endpackage : sq_gen_pkg
`default_nettype wire

// File: rtl/sq_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sq_gen_if                                                   |
// | Brief  : Control/status bundle of the square-wave generator.         |
// |          With SQ_GEN_BURST_EN defined, adds BURST_LEN and done.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface sq_gen_if
   import sq_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) ();

   logic             en;
   logic [CNT_W-1:0] PERIOD;
   logic [CNT_W-1:0] HIGH_TIME;
   logic             square;
   logic             period_start;
   logic [CNT_W-1:0] CNTPER;
`ifdef SQ_GEN_BURST_EN
   logic [CNT_W-1:0] BURST_LEN;
   logic             done;

   // Controller side: programs the generator and observes its outputs.
   modport master (
      output en, PERIOD, HIGH_TIME, BURST_LEN,
      input  square, period_start, CNTPER, done
   );

   // Generator side.
   modport slave (
      input  en, PERIOD, HIGH_TIME, BURST_LEN,
      output square, period_start, CNTPER, done
   );
`else
   // Controller side: programs the generator and observes its outputs.
   modport master (
      output en, PERIOD, HIGH_TIME,
      input  square, period_start, CNTPER
   );

   // Generator side.
   modport slave (
      input  en, PERIOD, HIGH_TIME,
      output square, period_start, CNTPER
   );
`endif

endinterface : sq_gen_if
`default_nettype wire

// File: rtl/sq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sq_gen                                                      |
// | Brief  : Programmable square-wave generator. Period and high time    |
// |          are counted in clk_in cycles and only take effect at period |
// |          boundaries, so no runt pulses are produced.                 |
// |          Optional macro SQ_GEN_BURST_EN adds burst-length control.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sq_gen
   import sq_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic     clk_in,
   input  logic     rst_n,
   sq_gen_if.slave  sq_io
);

   sq_state_e        state_q,  state_d;
   logic [CNT_W-1:0] phase_q,  phase_d;
   logic [CNT_W-1:0] per_q,    per_d;
   logic [CNT_W-1:0] hi_q,     hi_d;
   logic [CNT_W-1:0] cntper_q, cntper_d;
   logic             square_q, square_d;
   logic             pstart_q, pstart_d;

   logic [CNT_W-1:0] w_per_eff;
   logic [CNT_W-1:0] w_hi_eff;
   logic [CNT_W-1:0] w_phase_inc;
   logic [CNT_W-1:0] w_cntper_inc;
   logic             w_boundary;
   logic             w_start;

`ifdef SQ_GEN_BURST_EN
   logic [CNT_W-1:0] burst_q, burst_d;
   logic             done_q,  done_d;
   logic             lock_q,  lock_d;
   logic             w_burst_end;
`endif

   // Effective settings from the live inputs; only sampled into the
   // shadow registers at start and at period boundaries.
   assign w_per_eff    = (sq_io.PERIOD < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD)
                                                             : sq_io.PERIOD;
   assign w_hi_eff     = (sq_io.HIGH_TIME > w_per_eff) ? w_per_eff : sq_io.HIGH_TIME;
   assign w_phase_inc  = phase_q + 1'b1;
   assign w_cntper_inc = cntper_q + 1'b1;
   assign w_boundary   = (phase_q == (per_q - 1'b1));

`ifdef SQ_GEN_BURST_EN
   // After a completed burst, en must be seen low before a new start.
   assign w_start     = sq_io.en && !lock_q;
   assign w_burst_end = (burst_q != '0) && (w_cntper_inc == burst_q);
`else
   assign w_start     = sq_io.en;
`endif

   // State, phase counter, shadow registers and output registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         phase_q  <= '0;
         per_q    <= '0;
         hi_q     <= '0;
         cntper_q <= '0;
         square_q <= 1'b0;
         pstart_q <= 1'b0;
`ifdef SQ_GEN_BURST_EN
         burst_q  <= '0;
         done_q   <= 1'b0;
         lock_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         per_q    <= per_d;
         hi_q     <= hi_d;
         cntper_q <= cntper_d;
         square_q <= square_d;
         pstart_q <= pstart_d;
`ifdef SQ_GEN_BURST_EN
         burst_q  <= burst_d;
         done_q   <= done_d;
         lock_q   <= lock_d;
`endif
      end
   end

   // Next-state logic: start from IDLE, advance the phase, handle boundaries.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      per_d    = per_q;
      hi_d     = hi_q;
      cntper_d = cntper_q;
      square_d = square_q;
      pstart_d = 1'b0;
`ifdef SQ_GEN_BURST_EN
      burst_d  = burst_q;
      done_d   = 1'b0;
      lock_d   = sq_io.en ? lock_q : 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            square_d = 1'b0;
            if (w_start) begin
               per_d    = w_per_eff;
               hi_d     = w_hi_eff;
               phase_d  = '0;
               cntper_d = '0;
               square_d = (w_hi_eff != '0);
               pstart_d = 1'b1;
               state_d  = ST_RUN;
`ifdef SQ_GEN_BURST_EN
               burst_d  = sq_io.BURST_LEN;
`endif
            end
         end

         ST_RUN: begin
            if (!w_boundary) begin
               phase_d  = w_phase_inc;
               square_d = (w_phase_inc < hi_q);
            end else begin
               cntper_d = w_cntper_inc;
`ifdef SQ_GEN_BURST_EN
               if (w_burst_end) begin
                  state_d  = ST_IDLE;
                  phase_d  = '0;
                  square_d = 1'b0;
                  done_d   = 1'b1;
                  lock_d   = 1'b1;
               end else
`endif
               if (sq_io.en) begin
                  per_d    = w_per_eff;
                  hi_d     = w_hi_eff;
                  phase_d  = '0;
                  square_d = (w_hi_eff != '0);
                  pstart_d = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
                  phase_d  = '0;
                  square_d = 1'b0;
               end
            end
         end

         default: begin
            state_d  = ST_IDLE;
            square_d = 1'b0;
         end
      endcase
   end

   assign sq_io.square       = square_q;
   assign sq_io.period_start = pstart_q;
   assign sq_io.CNTPER       = cntper_q;
`ifdef SQ_GEN_BURST_EN
   assign sq_io.done         = done_q;
`endif

endmodule : sq_gen
`default_nettype wire
